// File: rtl/fifo_rd_fwft.sv
// rtl/fifo_rd_fwft.sv - FWFT valid/ready adapter for a 1-cycle-latency FIFO read port
module fifo_rd_fwft #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] rd_data,
  input  logic             rd_empty,
  output logic             rd_en,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;
  logic [2:0]       credit;

  always_comb begin
    pop        = (state_q != EMPTY) & out_ready;
    // Words already held plus the one in flight, less the one leaving, must leave room.
    credit     = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en      = rst_n & ~rd_empty & (credit < 3'd2);
    inflight_d = rd_en;
    state_d    = state_q;
    head_d     = head_q;
    skid_d     = skid_q;
    count_d    = pop ? count_q + CNT_W'(1) : count_q;
    case (state_q)
      EMPTY: begin
        if (inflight_q) begin
          head_d  = rd_data;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({inflight_q, pop})
          2'b10: begin
            skid_d  = rd_data;
            state_d = TWO;
          end
          2'b11: head_d = rd_data;
          2'b01: state_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          head_d = skid_q;
          if (inflight_q) skid_d = rd_data;
          else            state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      count_q    <= count_d;
    end
  end

  assign out_data  = head_q;
  assign out_valid = (state_q != EMPTY);
  assign out_count = count_q;

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && (state_q == TWO) && !pop));

endmodule
